pipe_register: RTL and testbench
================================

Name: pipe_register

Overview:
Parametrised, elastic, multi-stage register. Carries DATA_WIDTH-bit words through STAGES slots using a valid/ready handshake, with backpressure, bubble collapsing, synchronous flush and an occupancy count. It is the datapath staging element between KALI pipeline units where the plain clocked register cannot stall or discard.

Parameters:
DATA_WIDTH, 16, width of each data word
STAGES, 2, number of register slots (>=1); also the minimum in-to-out latency in cycles
RESET_VALUE, 0, value loaded into every slot's data register on reset

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous discard of all held words
in_valid  input  1  upstream offers in_data this cycle
in_ready  output  1  block accepts in_data this cycle
in_data  input  DATA_WIDTH  upstream word
out_valid  output  1  last slot holds a word
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  DATA_WIDTH  last slot's data register (meaningful only when out_valid=1)
count  output  $clog2(STAGES+1)  number of slots currently valid

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- State: slot i (0 = input side, STAGES-1 = output side) holds valid[i] and data[i].
- Reset (rst=1 at edge):
  - All valid[i] are cleared and every data[i] is set to RESET_VALUE.
  - After reset: out_valid=0, count=0, out_data=RESET_VALUE.
  - rst overrides flush and any handshake.
- Advance rule (combinational, evaluated from the output back to the input):
  - adv[STAGES-1] = !valid[STAGES-1] || out_ready
  - adv[i] = !valid[i] || adv[i+1]  (only when valid[i+1] would be occupied; equivalently, slot i may move forward if slot i+1 is empty or itself moving).
- Transfers on each edge with rst=0 and flush=0:
  - If adv[i+1] and valid[i]: data[i+1] <= data[i] and valid[i+1] <= 1.
  - If slot i+1 is leaving and valid[i]=0: valid[i+1] <= 0.
  - data[i+1] loads only on an actual transfer; otherwise it holds.
- Bubbles collapse: a stalled output does not block upstream slots that have empty slots ahead of them.
- Handshakes:
  - in_ready = adv[0] && !flush.
  - An input transfer occurs when in_valid && in_ready; slot 0 loads in_data and becomes valid.
  - An output transfer occurs when out_valid && out_ready.
  - in_ready is combinationally dependent on out_ready (no skid buffer). Upstream must not make in_valid depend on in_ready.
- Latency: with out_ready held at 1 and no stall, a word accepted at edge N appears with out_valid=1 after edge N+STAGES-1 and is consumed at edge N+STAGES.
- Throughput: one word per cycle sustained when out_ready=1.
- Flush (flush=1, rst=0):
  - Every valid[i] clears at the next edge.
  - data registers hold; they are not cleared.
  - in_ready=0 during the flush cycle, so no word is accepted.
  - An output transfer that completes in the same cycle still counts as delivered; the downstream sees it.
- Occupancy:
  - count = number of set valid bits, maintained as a registered up/down counter: +1 on input transfer, -1 on output transfer, unchanged on both or neither.
  - count is forced to 0 by rst or flush.
  - An assertion checks count against popcount(valid).
- Boundaries:
  - Full (count=STAGES) with out_ready=0: in_ready=0, all data held stable, out_data unchanged.
  - Full with out_ready=1: simultaneous in/out transfer; count stays at STAGES.
  - Empty: out_valid=0; out_data shows the last value held in the final slot.
  - STAGES=1: in_ready = !valid[0] || out_ready.
  - Reset in mid-stream discards all words; the first post-reset input is accepted one cycle after rst deasserts (in_ready=1 in that cycle).
- Stability: with out_valid=1 and out_ready=0, out_data and out_valid do not change until the transfer completes, except on rst or flush.

Decomposition:
- No shared package types are needed. The count width function ($clog2(STAGES+1)) goes in the common KALI constants package if one exists; otherwise it is a local parameter.
- Natural sub-module: pipe_stage, one slot with its valid and data flops and its advance logic. It is instantiated STAGES times in a generate loop.
- The counter and the handshake outputs live in pipe_register.

Test Plan:
- Streaming: STAGES=2, DATA_WIDTH=16, out_ready=1, feed 16'h0003, 16'h0009, 16'h8031 on consecutive cycles -> same words appear in order, first out_valid exactly 1 cycle after acceptance edge, count steady at 2 while streaming.
- Backpressure fill: out_ready=0, offer 16'h0006, 16'h0003, 16'h0008 -> first two accepted, in_ready=0 on the third, count=2, out_data=16'h0006 held stable; raise out_ready -> 16'h0006, 16'h0003, 16'h0008 delivered in order.
- Bubble collapse: STAGES=4, accept 16'hFFFF, idle 2 cycles, accept 16'h0000, out_ready=0 -> both words reach adjacent final slots, count=2, in_ready=1 (slots 0 and 1 free).
- Full simultaneous: full pipe with out_ready=1 and in_valid=1 for 5 cycles -> one in and one out per cycle, count stays at STAGES, no word dropped or duplicated.
- Flush: count=2, assert flush for one cycle with in_valid=1, in_data=16'h0011 -> in_ready=0 that cycle, next cycle count=0 and out_valid=0, 16'h0011 never appears at the output.
- Reset mid-operation: rst=1 with count=2 -> next edge out_valid=0, count=0, out_data=RESET_VALUE; the cycle after rst drops, in_ready=1 and 16'h0003 is accepted and delivered.

Source files
------------

// File: rtl/pipe_register_pkg.sv
// Shared constants and helpers for the elastic pipe register.
package pipe_register_pkg;

  // Width needed to count 0..stages occupied slots.
  function automatic int cnt_w(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_register_if.sv
// Valid/ready handshake bundle for both sides of the pipe register.
interface pipe_register_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  // Producer/consumer environment around the block.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The pipe register itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_register_stage.sv
// One slot of the elastic pipe: valid/data flops plus its move decision.
module pipe_stage #(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  prv_vld,
  input  logic [DATA_WIDTH-1:0] prv_dat,
  input  logic                  nxt_adv,
  output logic                  vld,
  output logic [DATA_WIDTH-1:0] dat
);

  logic adv;

  // Slot can take a new word if empty or if its current word moves on.
  assign adv = !vld || nxt_adv;

  // Data loads only on a real transfer; flush drops valid but keeps data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      dat <= RESET_VALUE;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (adv) begin
      vld <= prv_vld;
      if (prv_vld) dat <= prv_dat;
    end
  end

endmodule

// File: rtl/pipe_register.sv
// Elastic multi-stage register with backpressure, bubble collapse,
// flush and an occupancy counter.
module pipe_register
  import pipe_register_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    STAGES      = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  localparam int                   CW          = cnt_w(STAGES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_register_if.slave       bus,
  output logic [CW-1:0]        count
);

  logic [STAGES-1:0]                 vld;
  logic [STAGES-1:0][DATA_WIDTH-1:0] dat;
  logic [STAGES-1:0]                 adv_v;
  logic                              inc, dec;

  // Advance chain, walked from the output slot back to the input slot.
  always_comb begin
    logic a;
    a     = bus.out_ready;
    adv_v = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      a        = !vld[i] || a;
      adv_v[i] = a;
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic                  p_vld;
    logic [DATA_WIDTH-1:0] p_dat;
    logic                  n_adv;

    if (i == 0) begin : g_head
      assign p_vld = bus.in_valid;
      assign p_dat = bus.in_data;
    end else begin : g_body
      assign p_vld = vld[i-1];
      assign p_dat = dat[i-1];
    end

    if (i == STAGES - 1) begin : g_tail
      assign n_adv = bus.out_ready;
    end else begin : g_mid
      assign n_adv = adv_v[i+1];
    end

    pipe_stage #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .prv_vld (p_vld),
      .prv_dat (p_dat),
      .nxt_adv (n_adv),
      .vld     (vld[i]),
      .dat     (dat[i])
    );
  end

  assign bus.in_ready  = adv_v[0] && !flush;
  assign bus.out_valid = vld[STAGES-1];
  assign bus.out_data  = dat[STAGES-1];

  assign inc = bus.in_valid && bus.in_ready;
  assign dec = bus.out_valid && bus.out_ready;

  // Occupancy tracked as an up/down counter on the two handshakes.
  always_ff @(posedge clk) begin
    if (rst || flush)   count <= '0;
    else if (inc && !dec) count <= count + CW'(1);
    else if (dec && !inc) count <= count - CW'(1);
  end

  a_count_matches: assert property (@(posedge clk) disable iff (rst)
    count == CW'($countones(vld)));

endmodule

// File: tb/tb_pipe_register.sv
// Bench for pipe_register: vector table plus scoreboard on a 2-stage
// instance, hand sequences for reset and bubble collapse on a 4-stage one.
module tb_pipe_register;

  logic        clk = 1'b0;
  logic        rst;
  logic        fl2, fl4;
  logic [1:0]  cnt2;
  logic [2:0]  cnt4;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  pipe_register_if #(.DATA_WIDTH(16)) b2();
  pipe_register_if #(.DATA_WIDTH(16)) b4();

  pipe_register #(.DATA_WIDTH(16), .STAGES(2), .RESET_VALUE(16'h0000)) u2 (
    .clk(clk), .rst(rst), .flush(fl2), .bus(b2), .count(cnt2));

  pipe_register #(.DATA_WIDTH(16), .STAGES(4), .RESET_VALUE(16'h0000)) u4 (
    .clk(clk), .rst(rst), .flush(fl4), .bus(b4), .count(cnt4));

  typedef struct {
    logic        iv;
    logic [15:0] din;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [1:0]  e_cnt;
    logic [15:0] e_od;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic iv, logic [15:0] d, logic o, logic f,
                              logic ir, logic ov, logic [1:0] c, logic [15:0] od);
    vec_t v;
    v.iv = iv; v.din = d; v.ordy = o; v.fl = f;
    v.e_ir = ir; v.e_ov = ov; v.e_cnt = c; v.e_od = od;
    return v;
  endfunction

  // Scoreboard on the 2-stage instance: push on accept, pop on deliver.
  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      if (b2.out_valid && b2.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %h expected none at %0t", b2.out_data, $time);
        end else begin
          logic [15:0] e;
          e = sb.pop_front();
          chk("sb_data", {16'h0, b2.out_data}, {16'h0, e});
        end
      end
      if (b2.in_valid && b2.in_ready) sb.push_back(b2.in_data);
      if (fl2) sb.delete();
    end
  end

  task automatic drv4(input logic iv, input logic [15:0] d, input logic o);
    b4.in_valid = iv; b4.in_data = d; b4.out_ready = o;
  endtask

  initial begin
    int waits;
    rst = 1'b1; fl2 = 1'b0; fl4 = 1'b0;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b0;
    drv4(1'b0, 16'h0, 1'b0);

    //            iv  din       or  fl  ir  ov cnt od
    tbl[0]  = mk(0, 16'h0000, 1, 0, 1, 0, 0, 16'h0000);
    tbl[1]  = mk(1, 16'h0003, 1, 0, 1, 0, 0, 16'h0000);
    tbl[2]  = mk(1, 16'h0009, 1, 0, 1, 0, 1, 16'h0000);
    tbl[3]  = mk(1, 16'h8031, 1, 0, 1, 1, 2, 16'h0003);
    tbl[4]  = mk(0, 16'h0000, 1, 0, 1, 1, 2, 16'h0009);
    tbl[5]  = mk(0, 16'h0000, 1, 0, 1, 1, 1, 16'h8031);
    tbl[6]  = mk(0, 16'h0000, 0, 0, 1, 0, 0, 16'h8031);
    tbl[7]  = mk(1, 16'h0006, 0, 0, 1, 0, 0, 16'h8031);
    tbl[8]  = mk(1, 16'h0003, 0, 0, 1, 0, 1, 16'h8031);
    tbl[9]  = mk(1, 16'h0008, 0, 0, 0, 1, 2, 16'h0006);
    tbl[10] = mk(1, 16'h0008, 0, 0, 0, 1, 2, 16'h0006);
    tbl[11] = mk(1, 16'h0008, 1, 0, 1, 1, 2, 16'h0006);
    tbl[12] = mk(0, 16'h0000, 1, 0, 1, 1, 2, 16'h0003);
    tbl[13] = mk(0, 16'h0000, 1, 0, 1, 1, 1, 16'h0008);
    tbl[14] = mk(0, 16'h0000, 1, 0, 1, 0, 0, 16'h0008);
    tbl[15] = mk(1, 16'hA001, 0, 0, 1, 0, 0, 16'h0008);
    tbl[16] = mk(1, 16'hA002, 0, 0, 1, 0, 1, 16'h0008);
    tbl[17] = mk(1, 16'hA003, 1, 0, 1, 1, 2, 16'hA001);
    tbl[18] = mk(1, 16'hA004, 1, 0, 1, 1, 2, 16'hA002);
    tbl[19] = mk(1, 16'hA005, 1, 0, 1, 1, 2, 16'hA003);
    tbl[20] = mk(1, 16'hA006, 1, 0, 1, 1, 2, 16'hA004);
    tbl[21] = mk(1, 16'hA007, 1, 0, 1, 1, 2, 16'hA005);
    tbl[22] = mk(1, 16'h0011, 0, 1, 0, 1, 2, 16'hA006);
    tbl[23] = mk(0, 16'h0000, 1, 0, 1, 0, 0, 16'hA006);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      b2.in_valid = tbl[i].iv; b2.in_data = tbl[i].din;
      b2.out_ready = tbl[i].ordy; fl2 = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i),  {31'h0, b2.in_ready},  {31'h0, tbl[i].e_ir});
      chk($sformatf("v%0d_out_valid", i), {31'h0, b2.out_valid}, {31'h0, tbl[i].e_ov});
      chk($sformatf("v%0d_count", i),     {30'h0, cnt2},         {30'h0, tbl[i].e_cnt});
      chk($sformatf("v%0d_out_data", i),  {16'h0, b2.out_data},  {16'h0, tbl[i].e_od});
      @(posedge clk); #1;
    end
    b2.in_valid = 1'b0; fl2 = 1'b0;
    chk("sb_empty_after_flush", sb.size(), 0);

    // Reset mid-stream: load two words, then reset.
    b2.out_ready = 1'b0;
    b2.in_valid = 1'b1; b2.in_data = 16'hB001; @(posedge clk); #1;
    b2.in_data = 16'hB002; @(posedge clk); #1;
    b2.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", {30'h0, cnt2}, 32'd2);
    rst = 1'b1; @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'h0, b2.out_valid}, 32'd0);
    chk("rst_count",     {30'h0, cnt2},         32'd0);
    chk("rst_out_data",  {16'h0, b2.out_data},  32'h0000);
    chk("rst_in_ready",  {31'h0, b2.in_ready},  32'd1);
    // First cycle after reset: offer and accept immediately.
    @(posedge clk); #1;
    b2.in_valid = 1'b1; b2.in_data = 16'h0003; b2.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_accept", {31'h0, b2.in_ready}, 32'd1);
    @(posedge clk); #1;
    b2.in_valid = 1'b0;
    waits = 0;
    @(negedge clk);
    while (!b2.out_valid && waits < 8) begin
      @(posedge clk); #1;
      waits++;
      @(negedge clk);
    end
    chk("post_rst_latency", waits, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sb_empty_after_rst", sb.size(), 0);

    // Bubble collapse on the 4-stage instance with a stalled output.
    drv4(1'b1, 16'hFFFF, 1'b0); @(posedge clk); #1;
    drv4(1'b0, 16'h0000, 1'b0); repeat (2) begin @(posedge clk); #1; end
    drv4(1'b1, 16'h0000, 1'b0); @(posedge clk); #1;
    drv4(1'b0, 16'h0000, 1'b0); repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("bub_count",     {29'h0, cnt4},         32'd2);
    chk("bub_out_valid", {31'h0, b4.out_valid}, 32'd1);
    chk("bub_out_data",  {16'h0, b4.out_data},  32'hFFFF);
    chk("bub_in_ready",  {31'h0, b4.in_ready},  32'd1);
    @(posedge clk); #1;
    b4.out_ready = 1'b1;
    @(negedge clk);
    chk("bub_drain0", {16'h0, b4.out_data}, 32'hFFFF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bub_drain1_valid", {31'h0, b4.out_valid}, 32'd1);
    chk("bub_drain1",       {16'h0, b4.out_data},  32'h0000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bub_empty", {29'h0, cnt4}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
